// File: rtl/fpu_issue_if.sv
// Request/response channel between the FPU arbitration tree and the issue controller.
interface fpu_issue_if #(
    parameter int ID_WIDTH         = 9,
    parameter int NB_APU_ARGS      = 2,
    parameter int APU_OPCODE_WIDTH = 5,
    parameter int FLAG_WIDTH       = 6,
    parameter int STATUS_WIDTH     = 5,
    parameter int DATA_WIDTH       = 32
);
    logic                              data_req;
    logic [NB_APU_ARGS*DATA_WIDTH-1:0] data_operands;
    logic [APU_OPCODE_WIDTH-1:0]       data_op;
    logic [ID_WIDTH-1:0]               data_id;
    logic [FLAG_WIDTH-1:0]             data_flag;
    logic                              data_gnt;
    logic                              data_r_valid;
    logic [ID_WIDTH-1:0]               data_r_id;
    logic [DATA_WIDTH-1:0]             data_r_rdata;
    logic [STATUS_WIDTH-1:0]           data_r_flag;

    // Requester side (arbitration tree / response decoder)
    modport master (
        output data_req, data_operands, data_op, data_id, data_flag,
        input  data_gnt, data_r_valid, data_r_id, data_r_rdata, data_r_flag
    );

    // Controller side
    modport slave (
        input  data_req, data_operands, data_op, data_id, data_flag,
        output data_gnt, data_r_valid, data_r_id, data_r_rdata, data_r_flag
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue/writeback controller: steers arbitrated requests to the pipelined
// unit or the iterative div/sqrt unit, tracks requester IDs through both, and
// merges results onto one registered response channel with a 1-entry hold
// register for pipe/div writeback collisions.
module fpu_issue_ctrl #(
    parameter int ID_WIDTH         = 9,
    parameter int NB_APU_ARGS      = 2,
    parameter int APU_OPCODE_WIDTH = 5,
    parameter int FLAG_WIDTH       = 6,
    parameter int STATUS_WIDTH     = 5,
    parameter int DATA_WIDTH       = 32,
    parameter int PIPE_LAT         = 2,
    parameter logic [APU_OPCODE_WIDTH-1:0] DIV_OP  = 5'd4,
    parameter logic [APU_OPCODE_WIDTH-1:0] SQRT_OP = 5'd5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    fpu_issue_if.slave                        data,
    output logic                              fpu_pipe_valid_o,
    output logic                              fpu_div_valid_o,
    output logic [NB_APU_ARGS*DATA_WIDTH-1:0] fpu_operands_o,
    output logic [APU_OPCODE_WIDTH-1:0]       fpu_op_o,
    output logic [FLAG_WIDTH-1:0]             fpu_flag_o,
    input  logic [DATA_WIDTH-1:0]             fpu_pipe_result_i,
    input  logic [STATUS_WIDTH-1:0]           fpu_pipe_status_i,
    input  logic                              fpu_div_ready_i,
    input  logic                              fpu_div_done_i,
    input  logic [DATA_WIDTH-1:0]             fpu_div_result_i,
    input  logic [STATUS_WIDTH-1:0]           fpu_div_status_i
);

    logic                    is_div;
    logic                    accept;
    logic                    gnt;
    logic                    pipe_tail;
    logic                    div_done;

    logic                    pipe_vld_reg  [PIPE_LAT];
    logic                    pipe_vld_next [PIPE_LAT];
    logic [ID_WIDTH-1:0]     pipe_id_reg   [PIPE_LAT];
    logic [ID_WIDTH-1:0]     pipe_id_next  [PIPE_LAT];

    logic                    div_busy_reg;
    logic [ID_WIDTH-1:0]     div_id_reg;

    logic                    hold_valid_reg;
    logic [ID_WIDTH-1:0]     hold_id_reg;
    logic [DATA_WIDTH-1:0]   hold_data_reg;
    logic [STATUS_WIDTH-1:0] hold_status_reg;

    logic                    r_valid_reg;
    logic [ID_WIDTH-1:0]     r_id_reg;
    logic [DATA_WIDTH-1:0]   r_data_reg;
    logic [STATUS_WIDTH-1:0] r_status_reg;

    // Classify the request and decide whether its target unit can take it.
    // A pending hold blocks every issue so the pipe drains and the hold empties.
    always_comb begin
        is_div = (data.data_op == DIV_OP) || (data.data_op == SQRT_OP);
        accept = is_div ? (!div_busy_reg && !hold_valid_reg && fpu_div_ready_i)
                        : !hold_valid_reg;
        gnt    = rst_n && data.data_req && accept;
    end

    assign data.data_gnt    = gnt;
    assign fpu_pipe_valid_o = gnt && !is_div;
    assign fpu_div_valid_o  = gnt && is_div;
    assign fpu_operands_o   = data.data_operands;
    assign fpu_op_o         = data.data_op;
    assign fpu_flag_o       = data.data_flag;

    assign data.data_r_valid = r_valid_reg;
    assign data.data_r_id    = r_id_reg;
    assign data.data_r_rdata = r_data_reg;
    assign data.data_r_flag  = r_status_reg;

    // Tail of the tracker lines up with the pipe result; done only counts while a div is outstanding.
    assign pipe_tail = pipe_vld_reg[PIPE_LAT-1];
    assign div_done  = fpu_div_done_i && div_busy_reg;

    // Pipe tracker shift path: stage 0 loads the issue, later stages follow the previous one.
    assign pipe_vld_next[0] = gnt && !is_div;
    assign pipe_id_next[0]  = data.data_id;
    generate
        for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_pipe_stage
            assign pipe_vld_next[gi] = pipe_vld_reg[gi-1];
            assign pipe_id_next[gi]  = pipe_id_reg[gi-1];
        end
    endgenerate

    // Advance the pipe tracker; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_vld_reg[i] <= 1'b0;
            end
        end else begin
            pipe_vld_reg <= pipe_vld_next;
        end
        pipe_id_reg <= pipe_id_next;
    end

    // Div tracker: busy from issue until a qualified done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_busy_reg <= 1'b0;
        end else if (gnt && is_div) begin
            div_busy_reg <= 1'b1;
        end else if (div_done) begin
            div_busy_reg <= 1'b0;
        end
        if (gnt && is_div) begin
            div_id_reg <= data.data_id;
        end
    end

    // Capture the div result when it loses the writeback slot to the pipe tail.
    always_ff @(posedge clk) begin
        if (pipe_tail && div_done) begin
            hold_id_reg     <= div_id_reg;
            hold_data_reg   <= fpu_div_result_i;
            hold_status_reg <= fpu_div_status_i;
        end
    end

    // Writeback arbitration: pipe tail, then the hold register, then a direct div done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid_reg    <= 1'b0;
            r_id_reg       <= '0;
            r_data_reg     <= '0;
            r_status_reg   <= '0;
            hold_valid_reg <= 1'b0;
        end else begin
            r_valid_reg <= pipe_tail || hold_valid_reg || div_done;
            if (pipe_tail) begin
                r_id_reg     <= pipe_id_reg[PIPE_LAT-1];
                r_data_reg   <= fpu_pipe_result_i;
                r_status_reg <= fpu_pipe_status_i;
                if (div_done) begin
                    hold_valid_reg <= 1'b1;
                end
            end else if (hold_valid_reg) begin
                r_id_reg       <= hold_id_reg;
                r_data_reg     <= hold_data_reg;
                r_status_reg   <= hold_status_reg;
                hold_valid_reg <= 1'b0;
            end else if (div_done) begin
                r_id_reg     <= div_id_reg;
                r_data_reg   <= fpu_div_result_i;
                r_status_reg <= fpu_div_status_i;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: emulates both FPU units, keeps a
// queue-based model of in-flight work and expected responses, and checks every
// cycle, with directed scenarios pinned by literal expectations.
module tb_fpu_issue_ctrl;
    localparam int IDW = 9;
    localparam int NARGS = 2;
    localparam int OPW = 5;
    localparam int FLW = 6;
    localparam int STW = 5;
    localparam int DW = 32;
    localparam int LAT = 2;
    localparam logic [4:0] DIVOP  = 5'd4;
    localparam logic [4:0] SQRTOP = 5'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fpu_pipe_valid, fpu_div_valid;
    logic [NARGS*DW-1:0] fpu_operands;
    logic [OPW-1:0] fpu_op;
    logic [FLW-1:0] fpu_flag;
    logic [DW-1:0]  pipe_result, div_result;
    logic [STW-1:0] pipe_status, div_status;
    logic div_ready, div_done;

    fpu_issue_if #(.ID_WIDTH(IDW), .NB_APU_ARGS(NARGS), .APU_OPCODE_WIDTH(OPW),
                   .FLAG_WIDTH(FLW), .STATUS_WIDTH(STW), .DATA_WIDTH(DW)) bus ();

    fpu_issue_ctrl #(.ID_WIDTH(IDW), .NB_APU_ARGS(NARGS), .APU_OPCODE_WIDTH(OPW),
                     .FLAG_WIDTH(FLW), .STATUS_WIDTH(STW), .DATA_WIDTH(DW),
                     .PIPE_LAT(LAT), .DIV_OP(DIVOP), .SQRT_OP(SQRTOP)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .data              (bus.slave),
        .fpu_pipe_valid_o  (fpu_pipe_valid),
        .fpu_div_valid_o   (fpu_div_valid),
        .fpu_operands_o    (fpu_operands),
        .fpu_op_o          (fpu_op),
        .fpu_flag_o        (fpu_flag),
        .fpu_pipe_result_i (pipe_result),
        .fpu_pipe_status_i (pipe_status),
        .fpu_div_ready_i   (div_ready),
        .fpu_div_done_i    (div_done),
        .fpu_div_result_i  (div_result),
        .fpu_div_status_i  (div_status)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int             due;
        logic [IDW-1:0] id;
        logic [DW-1:0]  res;
        logic [STW-1:0] st;
        bit             tracked;
    } pipe_job_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  res;
        logic [STW-1:0] st;
    } resp_t;

    pipe_job_t pipe_q[$];   // work inside the emulated pipe unit
    resp_t     pend_q[$];   // div results waiting for a free writeback slot
    bit        m_div_busy = 0;
    logic [IDW-1:0] m_div_id = '0;
    bit        unit_busy = 0;
    int        unit_due = 0;

    bit             e_valid = 0;
    logic [IDW-1:0] e_id = '0;
    logic [DW-1:0]  e_data = '0;
    logic [STW-1:0] e_flag = '0;

    bit             s_req = 0;
    bit             s_rst_n = 0;
    logic [OPW-1:0] s_op = '0;
    logic [IDW-1:0] s_id = '0;
    int             s_div_lat = 0;
    bit             s_fix = 0;
    logic [DW-1:0]  s_fix_res = '0;
    bit             s_noise = 0;
    int             rst_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check combinational outputs, advance model.
    task automatic step();
        pipe_job_t cur;
        bit pipe_now, div_now, is_div, exp_gnt;
        @(posedge clk);
        #1;
        cyc++;
        chk("r_valid", 64'(bus.data_r_valid), 64'(e_valid));
        chk("r_id",    64'(bus.data_r_id),    64'(e_id));
        chk("r_rdata", 64'(bus.data_r_rdata), 64'(e_data));
        chk("r_flag",  64'(bus.data_r_flag),  64'(e_flag));
        if (bus.data_r_valid)
            $display("resp cyc=%0d id=%h rdata=%h status=%h", cyc, bus.data_r_id, bus.data_r_rdata, bus.data_r_flag);

        rst_n             = s_rst_n;
        bus.data_req      = s_req;
        bus.data_op       = s_op;
        bus.data_id       = s_id;
        bus.data_operands = {$urandom, $urandom};
        bus.data_flag     = FLW'($urandom);

        pipe_now = 0;
        cur = '{due: 0, id: '0, res: '0, st: '0, tracked: 0};
        if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
            cur = pipe_q.pop_front();
            pipe_result = cur.res;
            pipe_status = cur.st;
            pipe_now = cur.tracked;
        end else begin
            pipe_result = $urandom;
            pipe_status = STW'($urandom);
        end

        div_ready  = !unit_busy && (s_noise ? ($urandom_range(0, 7) != 0) : 1'b1);
        div_done   = 1'b0;
        div_result = $urandom;
        div_status = STW'($urandom);
        if (unit_busy && cyc == unit_due) begin
            div_done  = 1'b1;
            unit_busy = 0;
        end else if (!unit_busy && s_noise && $urandom_range(0, 15) == 0) begin
            div_done = 1'b1;   // stray pulse with nothing outstanding
        end
        #1;

        is_div  = (s_op == DIVOP) || (s_op == SQRTOP);
        exp_gnt = s_rst_n && s_req &&
                  (is_div ? (!m_div_busy && pend_q.size() == 0 && div_ready) : (pend_q.size() == 0));
        chk("gnt",        64'(bus.data_gnt),   64'(exp_gnt));
        chk("pipe_valid", 64'(fpu_pipe_valid), 64'(exp_gnt && !is_div));
        chk("div_valid",  64'(fpu_div_valid),  64'(exp_gnt && is_div));
        chk("pass_op",    64'(fpu_op),         64'(s_op));
        chk("pass_opnd",  64'(fpu_operands),   64'(bus.data_operands));
        chk("pass_flag",  64'(fpu_flag),       64'(bus.data_flag));

        if (!s_rst_n) begin
            e_valid = 0; e_id = '0; e_data = '0; e_flag = '0;
            pend_q.delete();
            m_div_busy = 0;
            foreach (pipe_q[i]) pipe_q[i].tracked = 0;
        end else begin
            div_now = div_done && m_div_busy;
            if (pipe_now) begin
                e_valid = 1; e_id = cur.id; e_data = cur.res; e_flag = cur.st;
                if (div_now) pend_q.push_back('{id: m_div_id, res: div_result, st: div_status});
            end else if (pend_q.size() > 0) begin
                resp_t r;
                r = pend_q.pop_front();
                e_valid = 1; e_id = r.id; e_data = r.res; e_flag = r.st;
            end else if (div_now) begin
                e_valid = 1; e_id = m_div_id; e_data = div_result; e_flag = div_status;
            end else begin
                e_valid = 0;
            end
            if (div_now) m_div_busy = 0;
            if (exp_gnt && !is_div)
                pipe_q.push_back('{due: cyc + LAT, id: s_id, res: (s_fix ? s_fix_res : $urandom),
                                   st: STW'($urandom), tracked: 1});
            if (exp_gnt && is_div) begin
                m_div_busy = 1;
                m_div_id   = s_id;
                unit_busy  = 1;
                unit_due   = cyc + ((s_div_lat > 0) ? s_div_lat : int'($urandom_range(1, 8)));
            end
        end
    endtask

    initial begin
        bus.data_req = 0; bus.data_op = '0; bus.data_id = '0;
        bus.data_operands = '0; bus.data_flag = '0;
        pipe_result = '0; pipe_status = '0; div_result = '0; div_status = '0;
        div_ready = 1; div_done = 0;

        // Reset state, with a request pending
        s_rst_n = 0; s_req = 1; s_op = 5'd0; s_id = 9'h001;
        repeat (3) step();
        chk("rst_gnt",     64'(bus.data_gnt),     64'd0);
        chk("rst_r_valid", 64'(bus.data_r_valid), 64'd0);
        chk("rst_r_id",    64'(bus.data_r_id),    64'd0);
        chk("rst_r_rdata", 64'(bus.data_r_rdata), 64'd0);
        s_rst_n = 1; s_req = 0;
        repeat (2) step();

        // Single pipe op
        s_req = 1; s_op = 5'd0; s_id = 9'h004; s_fix = 1; s_fix_res = 32'h3F800000;
        step();
        chk("single_gnt", 64'(bus.data_gnt), 64'd1);
        s_req = 0; s_fix = 0;
        step(); step();
        chk("single_early", 64'(bus.data_r_valid), 64'd0);
        step();
        chk("single_valid", 64'(bus.data_r_valid), 64'd1);
        chk("single_id",    64'(bus.data_r_id),    64'h004);
        chk("single_rdata", 64'(bus.data_r_rdata), 64'h3F800000);
        step();

        // Back-to-back pipe ops
        for (int k = 0; k < 4; k++) begin
            s_req = 1; s_op = 5'd1; s_id = 9'(1 << k);
            step();
            chk("b2b_gnt", 64'(bus.data_gnt), 64'd1);
        end
        chk("b2b_first", 64'(bus.data_r_id), 64'h001);
        s_req = 0;
        for (int k = 1; k < 4; k++) begin
            step();
            chk("b2b_valid", 64'(bus.data_r_valid), 64'd1);
            chk("b2b_id",    64'(bus.data_r_id),    64'(1 << k));
        end
        step();
        chk("b2b_end", 64'(bus.data_r_valid), 64'd0);

        // Div busy
        s_req = 1; s_op = DIVOP; s_id = 9'h010; s_div_lat = 4;
        step();
        chk("div_gnt", 64'(fpu_div_valid), 64'd1);
        s_op = SQRTOP; s_id = 9'h020;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("div_busy_gnt", 64'(bus.data_gnt), 64'd0);
        end
        step();
        chk("div_resp_valid", 64'(bus.data_r_valid), 64'd1);
        chk("div_resp_id",    64'(bus.data_r_id),    64'h010);
        chk("div_second_gnt", 64'(bus.data_gnt),     64'd1);
        s_req = 0;
        repeat (6) step();

        // Collision between pipe tail and div done
        s_req = 1; s_op = DIVOP; s_id = 9'h002; s_div_lat = 3;
        step();
        s_op = 5'd2; s_id = 9'h001;
        step();
        chk("col_pipe_gnt", 64'(bus.data_gnt), 64'd1);
        s_req = 0;
        step(); step();
        s_req = 1; s_op = 5'd3; s_id = 9'h008;
        step();
        chk("col_first_valid", 64'(bus.data_r_valid), 64'd1);
        chk("col_first_id",    64'(bus.data_r_id),    64'h001);
        chk("col_hold_gnt",    64'(bus.data_gnt),     64'd0);
        step();
        chk("col_second_valid", 64'(bus.data_r_valid), 64'd1);
        chk("col_second_id",    64'(bus.data_r_id),    64'h002);
        chk("col_after_gnt",    64'(bus.data_gnt),     64'd1);
        s_req = 0;
        repeat (4) step();

        // Reset with work in flight
        s_req = 1; s_op = DIVOP; s_id = 9'h040; s_div_lat = 6;
        step();
        s_op = 5'd0; s_id = 9'h080;
        step();
        s_id = 9'h100;
        step();
        s_rst_n = 0;
        step();
        chk("rst_mid_gnt", 64'(bus.data_gnt), 64'd0);
        step();
        s_rst_n = 1; s_req = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rst_mid_quiet", 64'(bus.data_r_valid), 64'd0);
        end
        chk("rst_mid_id",    64'(bus.data_r_id),    64'd0);
        chk("rst_mid_rdata", 64'(bus.data_r_rdata), 64'd0);
        s_req = 1; s_op = 5'd0; s_id = 9'h004; s_fix = 1; s_fix_res = 32'h40000000;
        step();
        chk("post_rst_gnt", 64'(bus.data_gnt), 64'd1);
        s_req = 0; s_fix = 0;
        repeat (3) step();
        chk("post_rst_valid", 64'(bus.data_r_valid), 64'd1);
        chk("post_rst_rdata", 64'(bus.data_r_rdata), 64'h40000000);

        // Randomized traffic
        s_noise = 1; s_div_lat = 0;
        for (int n = 0; n < 3000; n++) begin
            if (rst_cnt > 0) begin
                s_rst_n = 0;
                rst_cnt--;
            end else begin
                s_rst_n = 1;
                if ($urandom_range(0, 399) == 0) rst_cnt = 2;
            end
            s_req = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0)
                s_op = ($urandom_range(0, 1) == 1) ? DIVOP : SQRTOP;
            else
                s_op = OPW'($urandom);
            s_id = 9'(1 << $urandom_range(0, IDW - 1));
            step();
        end

        s_noise = 0; s_req = 0; s_rst_n = 1;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
